// File: rtl/intersections_pkg.sv
// Shared widths, FSM encoding and word-packing offsets for the circle-intersection engine.
package intersections_pkg;
    localparam int N_DEFAULT = 8;

    function automatic int calc_w(input int n);
        return 4 * n + 8;
    endfunction

    function automatic int calc_sqrt_bits(input int n);
        return 2 * n + 3;
    endfunction

    function automatic int calc_div_bits(input int n);
        return 2 * n + 4;
    endfunction

    // {x, y, r} input word: r at bit 0, y above it, x on top
    function automatic int in_y_lsb(input int n);
        return n + 1;
    endfunction

    function automatic int in_x_lsb(input int n);
        return 2 * n + 1;
    endfunction

    // {x1, y1, x2, y2} output word, each field n+2 bits
    function automatic int out_x2_lsb(input int n);
        return n + 2;
    endfunction

    function automatic int out_y1_lsb(input int n);
        return 2 * n + 4;
    endfunction

    function automatic int out_x1_lsb(input int n);
        return 3 * n + 6;
    endfunction

    typedef enum logic [2:0] {IDLE, LOAD, SQRT, PROD, DIV, OUT} state_e;
endpackage

// File: rtl/intersections_tg_seq_divider.sv
// seq_divider: signed restoring divider, one quotient bit per step, truncating toward zero.
module seq_divider #(
    parameter int W        = 40,
    parameter int DIV_BITS = 20,
    parameter int QW       = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 step,
    input  logic signed [W-1:0]  num,
    input  logic        [W-1:0]  den,
    output logic signed [QW-1:0] quo
);
    logic [W-1:0]        mag;
    logic [W-1:0]        rem_q, rem_d, rem_t;
    logic [DIV_BITS-1:0] lo_q, lo_d;
    logic [QW-1:0]       quo_q, quo_d;
    logic                neg_q, neg_d;
    logic                ge;

    // Only the low QW quotient bits are kept: the caller wraps modulo 2^QW anyway.
    always_comb begin
        mag   = num[W-1] ? -num : num;
        rem_t = (rem_q << 1) | W'(lo_q[DIV_BITS-1]);
        ge    = rem_t >= den;
        rem_d = rem_q;
        lo_d  = lo_q;
        quo_d = quo_q;
        neg_d = neg_q;
        if (load) begin
            neg_d = num[W-1];
            rem_d = mag >> DIV_BITS;
            lo_d  = mag[DIV_BITS-1:0];
            quo_d = '0;
        end else if (step) begin
            rem_d = ge ? rem_t - den : rem_t;
            lo_d  = lo_q << 1;
            quo_d = (quo_q << 1) | QW'(ge);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q <= '0;
            lo_q  <= '0;
            quo_q <= '0;
            neg_q <= 1'b0;
        end else begin
            rem_q <= rem_d;
            lo_q  <= lo_d;
            quo_q <= quo_d;
            neg_q <= neg_d;
        end
    end

    assign quo = neg_q ? -quo_q : quo_q;
endmodule

// File: rtl/intersections_tg_seq.sv
// Iterative two-circle intersection engine (sqrt inline, four serial dividers).
// Build option: define ROUND_NEAREST_EN for round-half-away-from-zero division.
//
// state | meaning
// IDLE  | waiting for start; inputs captured on accept
// LOAD  | D, A, R formed from captured circles; sqrt seeded
// SQRT  | one root bit per cycle
// PROD  | four numerators formed and loaded into dividers
// DIV   | one quotient bit per cycle in all dividers
// OUT   | result assembled; o and done registered on exit
module intersections_tg_seq
    import intersections_pkg::*;
#(
    parameter int N = N_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [3*N:0]   g_input,
    input  logic [3*N:0]   e_input,
    output logic [4*N+7:0] o,
    output logic           done,
    output logic           busy
);
    localparam int W         = calc_w(N);
    localparam int SQRT_BITS = calc_sqrt_bits(N);
    localparam int DIV_BITS  = calc_div_bits(N);
    localparam int QW        = N + 2;
    localparam int RW        = SQRT_BITS + 2;
    localparam int CW        = $clog2(DIV_BITS);
    localparam int RAD_SH    = W - 2 * SQRT_BITS;
    localparam int XO        = in_x_lsb(N);
    localparam int YO        = in_y_lsb(N);

    state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic signed [N-1:0] xk_q, yk_q, xl_q, yl_q, xk_d, yk_d, xl_d, yl_d;
    logic [N:0] rk_q, rl_q, rk_d, rl_d;
    logic [W-1:0] rad_q, rad_d;
    logic [RW-1:0] rem_q, rem_d, rem_t, trial;
    logic [SQRT_BITS-1:0] root_q, root_d;
    logic [4*N+7:0] o_q, o_d, res;
    logic done_q, done_d, start_ok, sq_ge;

    logic signed [W-1:0] dx, dy, d_sq, rk2, a_val, r_val, s_w, two_d;
    logic [W-1:0] r_cl;
    logic signed [W-1:0] num_raw [4];
    logic signed [W-1:0] num_div [4];
    logic signed [QW-1:0] quo [4];
    logic signed [QW-1:0] xk_o, yk_o;

    // The done cycle counts as busy, so a start there is dropped too.
    assign start_ok = start && !done_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start_ok) state_d = LOAD;
            LOAD: state_d = SQRT;
            SQRT: if (cnt_q == '0) state_d = PROD;
            PROD: state_d = DIV;
            DIV:  if (cnt_q == '0) state_d = OUT;
            OUT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        o_d    = o_q;
        done_d = 1'b0;
        busy   = (state_q != IDLE) || done_q;
        if (state_q == OUT) begin
            o_d    = res;
            done_d = 1'b1;
        end
    end

    always_comb begin
        dx    = W'(xl_q) - W'(xk_q);
        dy    = W'(yl_q) - W'(yk_q);
        d_sq  = dx * dx + dy * dy;
        two_d = d_sq <<< 1;
        rk2   = W'(rk_q) * W'(rk_q);
        a_val = rk2 - W'(rl_q) * W'(rl_q) + d_sq;
        r_val = ((rk2 * d_sq) <<< 2) - a_val * a_val;
        r_cl  = r_val[W-1] ? '0 : r_val;
        s_w   = W'(root_q);
        num_raw[0] = a_val * dx + s_w * dy;
        num_raw[1] = a_val * dy - s_w * dx;
        num_raw[2] = a_val * dx - s_w * dy;
        num_raw[3] = a_val * dy + s_w * dx;
        for (int i = 0; i < 4; i++) begin
`ifdef ROUND_NEAREST_EN
            if (num_raw[i] < 0)      num_div[i] = num_raw[i] - d_sq;
            else if (num_raw[i] > 0) num_div[i] = num_raw[i] + d_sq;
            else                     num_div[i] = num_raw[i];
`else
            num_div[i] = num_raw[i];
`endif
        end
        xk_o = QW'(xk_q);
        yk_o = QW'(yk_q);
        // Concentric circles: no meaningful intersection, report K's centre.
        if (d_sq == '0) res = {xk_o, yk_o, xk_o, yk_o};
        else res = {xk_o + quo[0], yk_o + quo[1], xk_o + quo[2], yk_o + quo[3]};
    end

    always_comb begin
        xk_d   = xk_q;
        yk_d   = yk_q;
        xl_d   = xl_q;
        yl_d   = yl_q;
        rk_d   = rk_q;
        rl_d   = rl_q;
        cnt_d  = cnt_q;
        rad_d  = rad_q;
        rem_d  = rem_q;
        root_d = root_q;
        rem_t  = (rem_q << 2) | RW'(rad_q[W-1 -: 2]);
        trial  = {root_q, 2'b01};
        sq_ge  = rem_t >= trial;
        case (state_q)
            IDLE: if (start_ok) begin
                xk_d = g_input[XO +: N];
                yk_d = g_input[YO +: N];
                rk_d = g_input[N:0];
                xl_d = e_input[XO +: N];
                yl_d = e_input[YO +: N];
                rl_d = e_input[N:0];
            end
            LOAD: begin
                rad_d  = r_cl << RAD_SH;
                rem_d  = '0;
                root_d = '0;
                cnt_d  = CW'(SQRT_BITS - 1);
            end
            SQRT: begin
                rad_d  = rad_q << 2;
                rem_d  = sq_ge ? rem_t - trial : rem_t;
                root_d = (root_q << 1) | SQRT_BITS'(sq_ge);
                cnt_d  = cnt_q - CW'(1);
            end
            PROD: cnt_d = CW'(DIV_BITS - 1);
            DIV:  cnt_d = cnt_q - CW'(1);
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xk_q   <= '0;
            yk_q   <= '0;
            xl_q   <= '0;
            yl_q   <= '0;
            rk_q   <= '0;
            rl_q   <= '0;
            cnt_q  <= '0;
            rad_q  <= '0;
            rem_q  <= '0;
            root_q <= '0;
            o_q    <= '0;
            done_q <= 1'b0;
        end else begin
            xk_q   <= xk_d;
            yk_q   <= yk_d;
            xl_q   <= xl_d;
            yl_q   <= yl_d;
            rk_q   <= rk_d;
            rl_q   <= rl_d;
            cnt_q  <= cnt_d;
            rad_q  <= rad_d;
            rem_q  <= rem_d;
            root_q <= root_d;
            o_q    <= o_d;
            done_q <= done_d;
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_div
        seq_divider #(
            .W        (W),
            .DIV_BITS (DIV_BITS),
            .QW       (QW)
        ) u_div (
            .clk  (clk),
            .rst  (rst),
            .load (state_q == PROD),
            .step (state_q == DIV),
            .num  (num_div[g]),
            .den  (two_d),
            .quo  (quo[g])
        );
    end

    assign o    = o_q;
    assign done = done_q;
endmodule

// File: tb/tb_intersections_tg_seq.sv
// Directed bench for intersections_tg_seq: hand-computed intersection points and timing.
module tb_intersections_tg_seq;
    localparam int N = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [3*N:0]   g_input;
    logic [3*N:0]   e_input;
    logic [4*N+7:0] o;
    logic           done;
    logic           busy;

    int n_checks = 0;
    int n_pass   = 0;
    int lat, ndone, first;

    always #5 clk = ~clk;

    intersections_tg_seq #(.N(N)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .g_input (g_input),
        .e_input (e_input),
        .o       (o),
        .done    (done),
        .busy    (busy)
    );

    function automatic logic [3*N:0] pk(input int x, input int y, input int r);
        logic [7:0] xb;
        logic [7:0] yb;
        logic [8:0] rb;
        xb = 8'(x);
        yb = 8'(y);
        rb = 9'(r);
        return {xb, yb, rb};
    endfunction

    function automatic logic [63:0] fld(input int idx);
        logic [9:0] f;
        f = o[(3 - idx) * 10 +: 10];
        return {{54{f[9]}}, f};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d, expected %0d", tag, $signed(obs), $signed(exp));
    endtask

    task automatic chk_fields(input string tag, input int x1, input int y1,
                              input int x2, input int y2);
        chk({tag, ".x1"}, fld(0), 64'(x1));
        chk({tag, ".y1"}, fld(1), 64'(y1));
        chk({tag, ".x2"}, fld(2), 64'(x2));
        chk({tag, ".y2"}, fld(3), 64'(y2));
    endtask

    task automatic launch(input logic [3*N:0] g, input logic [3*N:0] e);
        @(negedge clk);
        g_input = g;
        e_input = e;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = -1;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                cyc = k;
                break;
            end
        end
    endtask

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        g_input = '0;
        e_input = '0;
        repeat (3) @(negedge clk);
        chk("reset.o", 64'(o), 64'd0);
        chk("reset.done", 64'(done), 64'd0);
        chk("reset.busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        launch(pk(-16, -111, 236), pk(109, -99, 183));
        chk("t1.busy_early", 64'(busy), 64'd1);
        wait_done(lat);
        chk("t1.latency", 64'(lat), 64'd42);
`ifdef ROUND_NEAREST_EN
        chk_fields("t1", 152, -277, 117, 84);
`else
        chk_fields("t1", 151, -276, 117, 83);
`endif
        chk("t1.busy_at_done", 64'(busy), 64'd1);
        @(negedge clk);
        chk("t1.done_pulse", 64'(done), 64'd0);
        chk("t1.busy_after", 64'(busy), 64'd0);

        launch(pk(0, 0, 5), pk(8, 0, 5));
        wait_done(lat);
        chk("t2.latency", 64'(lat), 64'd42);
        chk_fields("t2", 4, -3, 4, 3);

        launch(pk(10, -20, 30), pk(10, -20, 40));
        wait_done(lat);
        chk("t3.latency", 64'(lat), 64'd42);
        chk_fields("t3", 10, -20, 10, -20);

        launch(pk(0, 0, 3), pk(20, 0, 3));
        wait_done(lat);
        chk("t4.latency", 64'(lat), 64'd42);
        chk_fields("t4", 10, 0, 10, 0);

        // Extra start pulses in SQRT (cycle 5) and OUT (cycle 41) must be dropped.
        launch(pk(0, 0, 5), pk(8, 0, 5));
        ndone = 0;
        first = -1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                ndone++;
                if (first < 0) first = k;
            end
            start = (k == 5 || k == 41);
            if (start) begin
                g_input = pk(10, -20, 30);
                e_input = pk(10, -20, 40);
            end
        end
        start = 1'b0;
        chk("t5.done_count", 64'(ndone), 64'd1);
        chk("t5.done_cycle", 64'(first), 64'd42);
        chk_fields("t5", 4, -3, 4, 3);
        chk("t5.busy_idle", 64'(busy), 64'd0);

        launch(pk(-16, -111, 236), pk(109, -99, 183));
        repeat (20) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("t6.rst_o", 64'(o), 64'd0);
        chk("t6.rst_done", 64'(done), 64'd0);
        chk("t6.rst_busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        launch(pk(10, -20, 30), pk(10, -20, 40));
        wait_done(lat);
        chk("t6.latency", 64'(lat), 64'd42);
        chk_fields("t6", 10, -20, 10, -20);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
